fxp_div_seq: RTL and testbench

//  Sequential signed fixed-point divider, the inverse of the CNN datapath multiplier.

---
 rtl/fxp_div_seq_pkg.sv | 13 +
 rtl/fxp_div_sat.sv | 44 ++++
 rtl/fxp_div_seq.sv | 131 +++++++++++++
 tb/tb_fxp_div_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fxp_div_seq_pkg.sv
// Shared definitions for the sequential fixed-point divider: default widths and FSM states.
package fxp_div_seq_pkg;

   localparam int CNN_XLEN  = 16;
   localparam int AUG_FCT_B = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/fxp_div_sat.sv
// Sign restore and saturation of the divider's quotient magnitude; also maps divide-by-zero.
module fxp_div_sat
   import fxp_div_seq_pkg::*;
#(
   parameter int DATA_WID = CNN_XLEN,
   parameter int QM_WID   = CNN_XLEN + AUG_FCT_B
) (
   input  logic [QM_WID-1:0]   qm,
   input  logic                sign,
   input  logic                dbz,
   input  logic                a_neg,
   output logic [DATA_WID-1:0] data,
   output logic                ovf
);

   localparam logic [DATA_WID-1:0] MAX_VAL = {1'b0, {(DATA_WID-1){1'b1}}};
   localparam logic [DATA_WID-1:0] MIN_VAL = {1'b1, {(DATA_WID-1){1'b0}}};
   localparam logic [QM_WID-1:0]   POS_LIM = QM_WID'(MAX_VAL);
   localparam logic [QM_WID-1:0]   NEG_LIM = QM_WID'(MIN_VAL);

   always_comb begin
      data = '0;
      ovf  = 1'b0;
      if (dbz) begin
         data = a_neg ? MIN_VAL : MAX_VAL;
      end else if (sign) begin
         // |min| is one larger than max, so the negative limit is inclusive of 2^(W-1)
         if (qm > NEG_LIM) begin
            data = MIN_VAL;
            ovf  = 1'b1;
         end else begin
            data = '0 - qm[DATA_WID-1:0];
         end
      end else begin
         if (qm > POS_LIM) begin
            data = MAX_VAL;
            ovf  = 1'b1;
         end else begin
            data = qm[DATA_WID-1:0];
         end
      end
   end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential signed fixed-point divider: Q = (A << FRAC_B) / B, radix-2 restoring on magnitudes.
module fxp_div_seq
   import fxp_div_seq_pkg::*;
#(
   parameter int DATA_WID = CNN_XLEN,
   parameter int FRAC_B   = AUG_FCT_B
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_WID-1:0] A,
   input  logic [DATA_WID-1:0] B,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_WID-1:0] data_out,
   output logic                ovf,
   output logic                dbz
);

   localparam int ITER  = DATA_WID + FRAC_B;
   localparam int CNT_W = $clog2(ITER);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_WID-1:0] rem_q, rem_d;
   logic [DATA_WID:0]   bm_q, bm_d;
   logic [ITER-1:0]     dq_q, dq_d;
   logic                sign_q, sign_d;
   logic                dbz_q, dbz_d;
   logic                a_neg_q, a_neg_d;

   logic signed [DATA_WID:0] a_ext, b_ext;
   logic [DATA_WID:0]        abs_a, abs_b;
   logic [DATA_WID:0]        rem_sh;
   logic                     accept;

   assign in_ready  = (state_q == IDLE) && reset;
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;

   always_comb begin
      a_ext  = {A[DATA_WID-1], A};
      b_ext  = {B[DATA_WID-1], B};
      abs_a  = a_ext[DATA_WID] ? -a_ext : a_ext;
      abs_b  = b_ext[DATA_WID] ? -b_ext : b_ext;
      rem_sh = {rem_q, dq_q[ITER-1]};

      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      bm_d    = bm_q;
      dq_d    = dq_q;
      sign_d  = sign_q;
      dbz_d   = dbz_q;
      a_neg_d = a_neg_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               bm_d    = abs_b;
               // |A| never exceeds 2^(W-1), so |A|<<FRAC_B fits the ITER-bit shift register
               dq_d    = ITER'({abs_a, {FRAC_B{1'b0}}});
               rem_d   = '0;
               sign_d  = A[DATA_WID-1] ^ B[DATA_WID-1];
               a_neg_d = A[DATA_WID-1];
               dbz_d   = (B == '0);
               cnt_d   = CNT_W'(ITER - 1);
               state_d = (B == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            // dq holds the unconsumed dividend bits on top and quotient bits shifting in below
            if (rem_sh >= bm_q) begin
               rem_d = DATA_WID'(rem_sh - bm_q);
               dq_d  = {dq_q[ITER-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[DATA_WID-1:0];
               dq_d  = {dq_q[ITER-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         bm_q    <= '0;
         dq_q    <= '0;
         sign_q  <= 1'b0;
         dbz_q   <= 1'b0;
         a_neg_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         bm_q    <= bm_d;
         dq_q    <= dq_d;
         sign_q  <= sign_d;
         dbz_q   <= dbz_d;
         a_neg_q <= a_neg_d;
      end
   end

   assign dbz = dbz_q;

   fxp_div_sat #(
      .DATA_WID (DATA_WID),
      .QM_WID   (ITER)
   ) u_sat (
      .qm    (dq_q),
      .sign  (sign_q),
      .dbz   (dbz_q),
      .a_neg (a_neg_q),
      .data  (data_out),
      .ovf   (ovf)
   );

endmodule

// File: tb/tb_fxp_div_seq.sv
// Directed bench for fxp_div_seq at DATA_WID=16, FRAC_B=8 with hand-computed quotients.
module tb_fxp_div_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] data_out;
   logic        ovf;
   logic        dbz;

   int total = 0;
   int bad   = 0;

   fxp_div_seq #(
      .DATA_WID (16),
      .FRAC_B   (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .ovf       (ovf),
      .dbz       (dbz)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the first negedge after the accept edge. lat counts rising edges from
   // the accept edge through the first edge that samples out_valid high.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic [15:0] a_i, input logic [15:0] b_i,
                        input logic [15:0] exp_d, input logic exp_o, input logic exp_z,
                        input int exp_lat);
      int lat;
      @(negedge clk);
      check({tag, "_rdy"}, in_ready, 1);
      in_valid = 1'b1;
      A        = a_i;
      B        = b_i;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(lat);
      check({tag, "_lat"},  lat, exp_lat);
      check({tag, "_data"}, data_out, exp_d);
      check({tag, "_ovf"},  ovf, exp_o);
      check({tag, "_dbz"},  dbz, exp_z);
      @(negedge clk);
      check({tag, "_clr"},  out_valid, 0);
   endtask

   initial begin
      int lat;
      int rises;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = '0;
      B         = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_data",      data_out, 16'h0000);
      check("rst_ovf",       ovf, 0);
      check("rst_dbz",       dbz, 0);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);

      do_op("p_div",   16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25);
      do_op("n_div",   16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25);
      do_op("third",   16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25);
      do_op("n_third", 16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25);
      do_op("zero_a",  16'h0000, 16'h0200, 16'h0000, 1'b0, 1'b0, 25);
      do_op("ovf_pos", 16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 25);
      do_op("min_m1",  16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 25);
      do_op("min_p1",  16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 25);
      do_op("ovf_neg", 16'h7F00, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 25);
      do_op("dbz_pos", 16'h0500, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1);
      do_op("dbz_neg", 16'hFB00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1);
      do_op("dbz_zero",16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1);

      // Backpressure: result held for 10 cycles while a new pair waits upstream
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      A        = 16'h0100;
      B        = 16'h0300;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(lat);
      check("bp_lat", lat, 25);
      in_valid = 1'b1;
      A        = 16'h0300;
      B        = 16'h0200;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid",    out_valid, 1);
         check("bp_data",     data_out, 16'h0055);
         check("bp_ovf",      ovf, 0);
         check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_xfer_valid", out_valid, 0);
      check("bp_xfer_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_busy", in_ready, 0);
      wait_valid(lat);
      check("bp2_lat",  lat, 25);
      check("bp2_data", data_out, 16'h0180);
      @(negedge clk);

      // Reset mid-CALC aborts the operation
      @(negedge clk);
      in_valid = 1'b1;
      A        = 16'h0300;
      B        = 16'h0200;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("ab_busy", in_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      check("ab_rst_valid", out_valid, 0);
      check("ab_rst_ready", in_ready, 0);
      check("ab_rst_data",  data_out, 16'h0000);
      reset = 1'b1;
      rises = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) rises++;
      end
      check("ab_no_valid", rises, 0);
      check("ab_ready",    in_ready, 1);
      do_op("ab_next", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25);

      // Reset while a result is pending in DONE
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      A        = 16'h0500;
      B        = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("dn_valid", out_valid, 1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("dn_rst_valid", out_valid, 0);
      check("dn_rst_dbz",   dbz, 0);
      out_ready = 1'b1;
      @(negedge clk);
      check("dn_ready", in_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
